// File: rtl/mcu_mailbox_pkg.sv
// mcu_mailbox_pkg: shared types and field positions for the MCU PIO mailbox.
//   opcode_t  - command opcodes carried in pio_cmd[30:29]
//   status_t  - response status codes carried in pio_rsp[30:29]
//   state_t   - mailbox sequencer states
//   cmd_parity() - XOR of the parity-covered command bits ([30:28], [15:0])
package mcu_mailbox_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_EMPTY      = 2'b01,
    ST_TIMEOUT    = 2'b10,
    ST_PARITY_ERR = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_TX_WAIT,
    S_RESP
  } state_t;

  // pio_cmd field positions
  localparam int CMD_REQ_BIT = 31;
  localparam int CMD_OP_HI   = 30;
  localparam int CMD_OP_LO   = 29;
  localparam int CMD_PAR_BIT = 28;
  localparam int CMD_PAY_HI  = 15;
  localparam int CMD_PAY_LO  = 0;

  // pio_rsp field positions
  localparam int RSP_ACK_BIT = 31;
  localparam int RSP_ST_HI   = 30;
  localparam int RSP_ST_LO   = 29;
  localparam int RSP_LVL_HI  = 23;
  localparam int RSP_LVL_LO  = 16;
  localparam int RSP_DAT_HI  = 15;
  localparam int RSP_DAT_LO  = 0;

  // Returns 1 when the covered bits have odd parity (i.e. the command is bad).
  function automatic logic cmd_parity(input logic [31:0] cmd);
    return ^{cmd[CMD_OP_HI:CMD_PAR_BIT], cmd[CMD_PAY_HI:CMD_PAY_LO]};
  endfunction

endpackage

// File: rtl/mcu_mailbox_fifo.sv
// mcu_mailbox_fifo: synchronous FIFO holding RX words for the mailbox.
//   clk, rst_n        - clock, asynchronous active-low reset
//   push, push_data   - write request / data (ignored when full)
//   pop               - read request (ignored when empty)
//   head_data         - current head word, valid whenever empty=0
//   level, full, empty - occupancy and flags
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module mcu_mailbox_fifo
  import mcu_mailbox_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read straight from storage so a pop can return it in the same cycle.
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mcu_pio_mailbox.sv
// mcu_pio_mailbox: toggle-handshake command mailbox on the MCU PIO pair.
//   clk_clk, reset_reset_n - clock, asynchronous active-low reset
//   pio_cmd  - [31] req_tgl, [30:29] opcode, [28] parity, [15:0] payload
//   pio_rsp  - [31] ack_tgl, [30:29] status, [23:16] live rx_level, [15:0] rsp_data
//   tx_*     - outgoing 16-bit valid/ready stream (WRITE)
//   rx_*     - incoming 16-bit valid/ready stream into the RX FIFO (READ)
// Optional: define MCU_MAILBOX_PARITY_EN to reject commands with odd parity
// over pio_cmd[30:28] and [15:0] (status PARITY_ERR, no side effects).
module mcu_pio_mailbox
  import mcu_mailbox_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] pio_cmd,
  output logic [31:0] pio_rsp,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t      state;
  opcode_t     op_reg;
  logic [15:0] payload_reg;
  logic        req_reg;
  logic        par_err_reg;
  status_t     pend_status;
  logic [15:0] pend_data;
  logic        ack_reg;
  status_t     status_reg;
  logic [15:0] rsp_data_reg;
  logic        tx_valid_reg;
  logic [15:0] tx_data_reg;
  logic [31:0] cnt_reg;

  logic [15:0]   fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    level8;

  // Bits that carry no function in this build.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^pio_cmd[CMD_PAR_BIT:16];

  assign fifo_pop = (state == S_EXEC) && (op_reg == OP_READ) && !par_err_reg && !fifo_empty;
  assign rx_ready = !fifo_full;

  mcu_mailbox_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  generate
    if (LW >= 8) begin : g_lvl_trunc
      assign level8 = fifo_level[7:0];
    end else begin : g_lvl_ext
      assign level8 = {{(8 - LW){1'b0}}, fifo_level};
    end
  endgenerate

  // Level is live; ack/status/data only change in RESP.
  assign pio_rsp  = {ack_reg, status_reg, 5'b0, level8, rsp_data_reg};
  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= S_IDLE;
      op_reg       <= OP_NOP;
      payload_reg  <= '0;
      req_reg      <= 1'b0;
      par_err_reg  <= 1'b0;
      pend_status  <= ST_OK;
      pend_data    <= '0;
      ack_reg      <= 1'b0;
      status_reg   <= ST_OK;
      rsp_data_reg <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pio_cmd[CMD_REQ_BIT] != ack_reg) begin
            op_reg      <= opcode_t'(pio_cmd[CMD_OP_HI:CMD_OP_LO]);
            payload_reg <= pio_cmd[CMD_PAY_HI:CMD_PAY_LO];
            req_reg     <= pio_cmd[CMD_REQ_BIT];
`ifdef MCU_MAILBOX_PARITY_EN
            par_err_reg <= cmd_parity(pio_cmd);
`else
            par_err_reg <= 1'b0;
`endif
            state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (par_err_reg) begin
            pend_status <= ST_PARITY_ERR;
            pend_data   <= '0;
            state       <= S_RESP;
          end else begin
            case (op_reg)
              OP_NOP: begin
                pend_status <= ST_OK;
                pend_data   <= '0;
                state       <= S_RESP;
              end
              OP_READ: begin
                pend_status <= fifo_empty ? ST_EMPTY : ST_OK;
                pend_data   <= fifo_empty ? 16'h0000 : fifo_head;
                state       <= S_RESP;
              end
              OP_STATUS: begin
                pend_status <= ST_OK;
                pend_data   <= {14'b0, fifo_full, fifo_empty};
                state       <= S_RESP;
              end
              default: begin // OP_WRITE
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= payload_reg;
                cnt_reg      <= '0;
                state        <= S_TX_WAIT;
              end
            endcase
          end
        end

        S_TX_WAIT: begin
          // cnt_reg counts completed TX_WAIT cycles; the handshake is checked
          // first so a last-cycle handshake beats the timeout.
          if (tx_ready) begin
            tx_valid_reg <= 1'b0;
            pend_status  <= ST_OK;
            pend_data    <= payload_reg;
            state        <= S_RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == 32'(TIMEOUT_CYCLES - 1))) begin
            tx_valid_reg <= 1'b0;
            pend_status  <= ST_TIMEOUT;
            pend_data    <= payload_reg;
            state        <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
          end
        end

        default: begin // S_RESP
          ack_reg      <= req_reg;
          status_reg   <= pend_status;
          rsp_data_reg <= pend_data;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
